// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader sitting in front of the 512x32 RAM override port. A host
// streams bytes over a valid/ready handshake; the loader packs them big-endian
// into DATA_WIDTH-bit words and writes each word to consecutive RAM addresses,
// waiting for the RAM's done indication after every write strobe. The CPU is
// held in reset for the whole load.
//
// Ports:
//   Clock            rising-edge system clock
//   reset            synchronous, active-high reset
//   start            one-cycle load request (ignored while busy)
//   start_address    first RAM address, sampled on an accepted start
//   word_count       words to load (0..2^ADDR_WIDTH), sampled on start
//   rx_data/rx_valid incoming byte stream
//   rx_ready         byte accepted on this edge when rx_valid is also high
//   memory_done      RAM write-complete indication
//   overide, overide_address, overide_data_in
//                    RAM override select, write address and write data
//   mem_write, mem_read, mem_enable
//                    RAM strobes (mem_read is always 0)
//   cpu_hold         keeps Control/DataPath in reset while a load runs
//   busy             load in progress
//   load_done        one-cycle pulse on successful completion
//   error            sticky fault flag (range error or RAM timeout)
// ----------------------------------------------------------------------------
module program_loader #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 9,
   parameter int DONE_TIMEOUT = 15
) (
   input  logic                  Clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_address,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  memory_done,
   output logic                  overide,
   output logic [ADDR_WIDTH-1:0] overide_address,
   output logic [DATA_WIDTH-1:0] overide_data_in,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic                  mem_enable,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  load_done,
   output logic                  error
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW    = $clog2(DONE_TIMEOUT + 1);

   // One past the last legal RAM address, in the width of the range sum.
   localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      FINISH  = 2'd3
   } state_t;

   state_t state, next_state;

   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH:0]   words_written;
   logic [BCW-1:0]        byte_cnt;
   logic [DATA_WIDTH-1:0] word_reg;
   logic [TW-1:0]         timeout_cnt;

   // Event flags decoded by the next-state logic and consumed by the datapath.
   logic start_load;
   logic start_zero;
   logic start_bad;
   logic byte_take;
   logic byte_last;
   logic write_ok;
   logic write_timeout;

   logic [ADDR_WIDTH+1:0] end_sum;
   logic [DATA_WIDTH+7:0] shift_word;

   // Two-bit-wider sum so start_address + word_count cannot overflow.
   assign end_sum    = {2'b00, start_address} + {1'b0, word_count};
   assign shift_word = {word_reg, rx_data};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and event decode
   // ------------------------------------------------------------------
   always_comb begin
      next_state    = state;
      start_load    = 1'b0;
      start_zero    = 1'b0;
      start_bad     = 1'b0;
      byte_take     = 1'b0;
      byte_last     = 1'b0;
      write_ok      = 1'b0;
      write_timeout = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (word_count == '0) begin
                  start_zero = 1'b1;
                  next_state = FINISH;
               end else if (end_sum > ADDR_SPAN) begin
                  start_bad = 1'b1;
               end else begin
                  start_load = 1'b1;
                  next_state = COLLECT;
               end
            end
         end

         COLLECT: begin
            if (rx_valid) begin
               byte_take = 1'b1;
               if (byte_cnt == BCW'(BYTES - 1)) begin
                  byte_last  = 1'b1;
                  next_state = WRITE;
               end
            end
         end

         WRITE: begin
            if (memory_done) begin
               write_ok = 1'b1;
               if ((words_written + (ADDR_WIDTH+1)'(1)) == word_cnt) begin
                  next_state = FINISH;
               end else begin
                  next_state = COLLECT;
               end
            end else if (timeout_cnt == TW'(DONE_TIMEOUT - 1)) begin
               // This is the DONE_TIMEOUT-th strobe cycle with no done.
               write_timeout = 1'b1;
               next_state    = IDLE;
            end
         end

         FINISH: begin
            next_state = IDLE;
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Address, counters, word assembly and error flag
   // ------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (reset) begin
         addr          <= '0;
         word_cnt      <= '0;
         words_written <= '0;
         byte_cnt      <= '0;
         word_reg      <= '0;
         timeout_cnt   <= '0;
         error         <= 1'b0;
      end else begin
         if (start_bad) begin
            error <= 1'b1;
         end

         if (start_load || start_zero) begin
            error <= 1'b0;
         end

         if (start_load) begin
            addr          <= start_address;
            word_cnt      <= word_count;
            words_written <= '0;
            byte_cnt      <= '0;
            word_reg      <= '0;
            timeout_cnt   <= '0;
         end

         // Shifting left places the first byte of a word in the top lane.
         if (byte_take) begin
            word_reg <= shift_word[DATA_WIDTH-1:0];
            byte_cnt <= byte_last ? '0 : byte_cnt + BCW'(1);
         end

         if (write_ok) begin
            addr          <= addr + ADDR_WIDTH'(1);
            words_written <= words_written + (ADDR_WIDTH+1)'(1);
            timeout_cnt   <= '0;
         end else if (write_timeout) begin
            error       <= 1'b1;
            timeout_cnt <= '0;
         end else if (state == WRITE) begin
            timeout_cnt <= timeout_cnt + TW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // State-decoded outputs
   // ------------------------------------------------------------------
   assign busy            = (state != IDLE);
   assign cpu_hold        = busy;
   assign rx_ready        = (state == COLLECT);
   assign overide         = (state == WRITE);
   assign mem_write       = (state == WRITE);
   assign mem_enable      = (state == WRITE);
   assign mem_read        = 1'b0;
   assign load_done       = (state == FINISH);
   assign overide_address = (state == WRITE) ? addr : '0;
   assign overide_data_in = (state == WRITE) ? word_reg : '0;

endmodule
